// File: rtl/sale_terminal_pkg.sv
// Shared types and constants for the sale-terminal barcode entry path.
// Holds the button debounce state encoding and the barcode/BCD limits.
package sale_terminal_pkg;

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } deb_state_e;

    localparam int unsigned BARCODE_DIGITS = 4;
    localparam int unsigned MAX_BCD        = 9;

    // Width of a counter able to reach (larger of a, b) - 1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser and debounce FSM for one active-low push-button.
// Emits a registered one-cycle press event once the low level has been stable.
module button_debouncer
    import sale_terminal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES, 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_ni,
    output logic press_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MaxCnt  = {CNT_W{1'b1}};

    logic [1:0]       sync_q, sync_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             level;

    assign level = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn_ni};
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;

        unique case (state_q)
            StReleased: begin
                if (!level) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (level) begin
                    state_d = StReleased;
                end else if (cnt_q == LastCnt) begin
                    state_d = StPressed;
                    press_d = 1'b1;
                end else if (cnt_q != MaxCnt) begin
                    cnt_d = cnt_q + OneCnt;
                end
            end
            StPressed: begin
                if (level) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                // A bounce back low returns to PRESSED without a second event.
                if (!level) begin
                    state_d = StPressed;
                end else if (cnt_q == LastCnt) begin
                    state_d = StReleased;
                end else if (cnt_q != MaxCnt) begin
                    cnt_d = cnt_q + OneCnt;
                end
            end
            default: begin
                state_d = StReleased;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= StReleased;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/barcode_digit_entry.sv
// Digit entry front-end: debounced ENTER/CLEAR, digit commit/reject and clear pulses.
// Optional macro ENTRY_TIMEOUT_EN adds an idle auto-clear for partial entries.
module barcode_digit_entry
    import sale_terminal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_DIGITS      = BARCODE_DIGITS,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KEY_ENTER_N,
    input  logic       KEY_CLEAR_N,
    input  logic [3:0] SW_DIGIT,
    output logic [3:0] Digit_out,
    output logic       Digit_valid,
    output logic       Clear_pulse,
    output logic [2:0] Digit_count,
    output logic       Entry_full,
    output logic       Reject_pulse
);

    localparam int unsigned CNT_W    = cnt_width(DEBOUNCE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [2:0]  MaxCount = 3'(MAX_DIGITS);
    localparam logic [3:0]  MaxBcd   = 4'(MAX_BCD);

    logic       enter_ev, clear_ev, timeout_ev;
    logic [3:0] sw_sync1_q, sw_sync2_q;
    logic [3:0] digit_out_q, digit_out_d;
    logic       valid_q, valid_d;
    logic       clear_q, clear_d;
    logic       reject_q, reject_d;
    logic [2:0] count_q, count_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_enter_deb (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_ni  (KEY_ENTER_N),
        .press_o (enter_ev)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_clear_deb (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_ni  (KEY_CLEAR_N),
        .press_o (clear_ev)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] IdleLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] IdleOne  = CNT_W'(1);

    logic [CNT_W-1:0] idle_q, idle_d;
    logic             partial;

    assign partial = (count_q != 3'd0) && (count_q < MaxCount);

    always_comb begin
        idle_d     = idle_q;
        timeout_ev = 1'b0;
        if (enter_ev || clear_ev || !partial) begin
            idle_d = '0;
        end else if (idle_q == IdleLast) begin
            timeout_ev = 1'b1;
        end else begin
            idle_d = idle_q + IdleOne;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_ev = 1'b0;
`endif

    always_comb begin
        digit_out_d = digit_out_q;
        count_d     = count_q;
        valid_d     = 1'b0;
        clear_d     = 1'b0;
        reject_d    = 1'b0;

        // Clear beats a same-cycle commit, and the dropped commit is not rejected.
        if (clear_ev || timeout_ev) begin
            clear_d = 1'b1;
            count_d = 3'd0;
        end else if (enter_ev) begin
            if ((count_q < MaxCount) && (sw_sync2_q <= MaxBcd)) begin
                digit_out_d = sw_sync2_q;
                valid_d     = 1'b1;
                count_d     = count_q + 3'd1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_sync1_q  <= 4'd0;
            sw_sync2_q  <= 4'd0;
            digit_out_q <= 4'd0;
            valid_q     <= 1'b0;
            clear_q     <= 1'b0;
            reject_q    <= 1'b0;
            count_q     <= 3'd0;
        end else begin
            sw_sync1_q  <= SW_DIGIT;
            sw_sync2_q  <= sw_sync1_q;
            digit_out_q <= digit_out_d;
            valid_q     <= valid_d;
            clear_q     <= clear_d;
            reject_q    <= reject_d;
            count_q     <= count_d;
        end
    end

    assign Digit_out    = digit_out_q;
    assign Digit_valid  = valid_q;
    assign Clear_pulse  = clear_q;
    assign Reject_pulse = reject_q;
    assign Digit_count  = count_q;
    assign Entry_full   = (count_q == MaxCount);

endmodule

// File: tb/tb_barcode_digit_entry.sv
// Self-checking bench for barcode_digit_entry: directed scenarios plus random
// button actions checked against a rule-level model of the entry behaviour.
module tb_barcode_digit_entry;

    localparam int unsigned DEB  = 4;
    localparam int unsigned MAXD = 4;
    localparam int unsigned TMO  = 20;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       KEY_ENTER_N = 1'b1;
    logic       KEY_CLEAR_N = 1'b1;
    logic [3:0] SW_DIGIT = 4'd0;
    logic [3:0] Digit_out;
    logic       Digit_valid;
    logic       Clear_pulse;
    logic [2:0] Digit_count;
    logic       Entry_full;
    logic       Reject_pulse;

    barcode_digit_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .MAX_DIGITS      (MAXD),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .KEY_ENTER_N  (KEY_ENTER_N),
        .KEY_CLEAR_N  (KEY_CLEAR_N),
        .SW_DIGIT     (SW_DIGIT),
        .Digit_out    (Digit_out),
        .Digit_valid  (Digit_valid),
        .Clear_pulse  (Clear_pulse),
        .Digit_count  (Digit_count),
        .Entry_full   (Entry_full),
        .Reject_pulse (Reject_pulse)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    int n_clear = 0;
    int n_reject = 0;
    int cyc = 0;
    int last_clear_cyc = -1;
    int last_valid_cyc = -1;

    // Reference model state
    int         m_count = 0;
    logic [3:0] m_digit = 4'd0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge
    always @(negedge CLK) begin
        cyc++;
        if (!RESET) begin
            if (Digit_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (Clear_pulse) begin
                n_clear++;
                last_clear_cyc = cyc;
            end
            if (Reject_pulse) n_reject++;
            if ((Digit_valid + Clear_pulse + Reject_pulse) > 1)
                check("pulse_exclusive", Digit_valid + Clear_pulse + Reject_pulse, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input bit enter, input bit clear, input int hold);
        if (enter) KEY_ENTER_N = 1'b0;
        if (clear) KEY_CLEAR_N = 1'b0;
        tick(hold);
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        tick(14);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, Digit_count, m_count);
        check({tag, ".full"}, Entry_full, (m_count == MAXD) ? 1 : 0);
        check({tag, ".digit"}, Digit_out, m_digit);
    endtask

    // kind: 0 enter, 1 clear, 2 enter+clear together, 3 three short glitches on enter
    task automatic act(input string tag, input int kind, input logic [3:0] d);
        int v0, c0, r0, ev, ec, er;
        v0 = n_valid; c0 = n_clear; r0 = n_reject;
        ev = 0; ec = 0; er = 0;
        SW_DIGIT = d;
        tick(4);
        case (kind)
            0: press(1'b1, 1'b0, 10);
            1: press(1'b0, 1'b1, 10);
            2: press(1'b1, 1'b1, 10);
            default: repeat (3) press(1'b1, 1'b0, 2);
        endcase
        case (kind)
            0: begin
                if (m_count < MAXD && d <= 9) begin
                    ev = 1;
                    m_digit = d;
                    m_count++;
                end else begin
                    er = 1;
                end
            end
            1, 2: begin
                ec = 1;
                m_count = 0;
            end
            default: ;
        endcase
        check({tag, ".valid"}, n_valid - v0, ev);
        check({tag, ".clear"}, n_clear - c0, ec);
        check({tag, ".reject"}, n_reject - r0, er);
        check_state(tag);
    endtask

    initial begin
        int v0, c0, r0, k, t0;
        bit seen;

        // Reset values
        tick(5);
        check("rst.digit_out", Digit_out, 0);
        check("rst.valid", Digit_valid, 0);
        check("rst.clear", Clear_pulse, 0);
        check("rst.count", Digit_count, 0);
        check("rst.full", Entry_full, 0);
        check("rst.reject", Reject_pulse, 0);
        RESET = 1'b0;
        tick(3);

        act("glitch", 3, 4'd6);
        act("enter7", 0, 4'd7);
        act("clr0", 1, 4'd0);

        act("fill1", 0, 4'd1);
        act("fill2", 0, 4'd2);
        act("fill3", 0, 4'd3);
        act("fill4", 0, 4'd4);
        act("over5", 0, 4'd5);
        act("clr1", 1, 4'd0);

        act("bad12", 0, 4'd12);
        act("pre1", 0, 4'd1);
        act("pre2", 0, 4'd2);
        act("both", 2, 4'd8);

        // Reset while ENTER is in PRESS_WAIT; the button is released during reset
        act("rpre1", 0, 4'd5);
        act("rpre2", 0, 4'd6);
        SW_DIGIT = 4'd3;
        tick(4);
        v0 = n_valid; r0 = n_reject;
        KEY_ENTER_N = 1'b0;
        tick(3);
        RESET = 1'b1;
        tick(2);
        KEY_ENTER_N = 1'b1;
        tick(2);
        RESET = 1'b0;
        m_count = 0;
        m_digit = 4'd0;
        tick(20);
        check("rst_mid.valid", n_valid - v0, 0);
        check("rst_mid.reject", n_reject - r0, 0);
        check_state("rst_mid");

`ifdef ENTRY_TIMEOUT_EN
        // One digit, then idle: an auto-clear arrives about TIMEOUT_CYCLES later
        c0 = n_clear;
        SW_DIGIT = 4'd3;
        tick(4);
        KEY_ENTER_N = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (last_valid_cyc > 0 && n_valid > v0) seen = 1'b1;
        end
        check("tmo.commit_seen", seen, 1);
        t0 = last_valid_cyc;
        KEY_ENTER_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (n_clear > c0) seen = 1'b1;
        end
        check("tmo.clear_seen", seen, 1);
        k = last_clear_cyc - t0;
        check("tmo.delay_ok", (k >= 19 && k <= 21) ? 1 : 0, 1);
        m_count = 0;
        m_digit = 4'd3;
        tick(20);
        check("tmo.one_clear", n_clear - c0, 1);
        check_state("tmo");
`else
        // Without the timeout a partial entry persists
        act("persist", 0, 4'd3);
        c0 = n_clear;
        tick(80);
        check("persist.clear", n_clear - c0, 0);
        check_state("persist");
        act("persist_clr", 1, 4'd0);

        // Random button actions against the model
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            if (k <= 4)      act($sformatf("rnd%0d", i), 0, 4'($urandom_range(0, 15)));
            else if (k == 5) act($sformatf("rnd%0d", i), 1, 4'($urandom_range(0, 15)));
            else if (k == 6) act($sformatf("rnd%0d", i), 2, 4'($urandom_range(0, 15)));
            else             act($sformatf("rnd%0d", i), 3, 4'($urandom_range(0, 15)));
        end
        seen = 1'b0;
        t0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/barcode_digit_entry.md
Name: barcode_digit_entry

Overview:
Front-end digit entry stage for the barcode path. Synchronises and debounces the raw ENTER and CLEAR push-buttons and samples the 4-bit digit switches. Emits one-cycle digit-commit pulses, which drive the barcode shift register's ENABLE and Digit_in directly. Tracks how many digits have been entered, locks out entry once the barcode is full, and issues a clear pulse to restart entry.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must stay stable before it is accepted (20 ms at 50 MHz).
MAX_DIGITS, 4, digits per barcode; commits beyond this are rejected.
TIMEOUT_CYCLES, 250000000, idle cycles before a partial entry auto-clears (used only with ENTRY_TIMEOUT_EN).

Ports:
CLK  in  1  system clock (CLOCK_50).
RESET  in  1  synchronous, active-high reset.
KEY_ENTER_N  in  1  raw asynchronous push-button, active-low; a press commits the current digit.
KEY_CLEAR_N  in  1  raw asynchronous push-button, active-low; a press clears the entry.
SW_DIGIT  in  4  raw digit switches.
Digit_out  out  4  committed digit; drives the shift register's Digit_in.
Digit_valid  out  1  one-cycle commit strobe; drives the shift register's ENABLE.
Clear_pulse  out  1  one-cycle clear request to the barcode path.
Digit_count  out  3  digits accepted since the last clear (0..MAX_DIGITS).
Entry_full  out  1  high while Digit_count == MAX_DIGITS.
Reject_pulse  out  1  one-cycle strobe when a commit is refused.

Behaviour:
- Reset values: Digit_out=0, Digit_valid=0, Clear_pulse=0, Digit_count=0, Entry_full=0, Reject_pulse=0. All synchroniser, debounce and timeout state returns to idle/released.
- Synchronisers: each of KEY_ENTER_N, KEY_CLEAR_N and SW_DIGIT passes through two flops before use. Two-flop latency is fixed.
- Debounce FSM, one per button:
  - States: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED -> PRESS_WAIT when the synchronised level goes low; counter loads 0.
  - PRESS_WAIT: counter increments while the level stays low. If the level goes high -> RELEASED, no event. When the counter reaches DEBOUNCE_CYCLES-1 -> PRESSED and a one-cycle press event is raised.
  - PRESSED -> RELEASE_WAIT when the level goes high.
  - RELEASE_WAIT: counts stable-high cycles the same way; a low level -> PRESSED. Full count -> RELEASED.
  - Exactly one press event per physical press; holding the button gives no repeats.
- Commit, on an ENTER press event:
  - If Digit_count < MAX_DIGITS and the synchronised SW_DIGIT <= 9: the next cycle has Digit_out = the sampled switches, Digit_valid=1 for one cycle, and Digit_count +1.
  - Otherwise (digit > 9 or entry full): Reject_pulse=1 for one cycle. Digit_out, Digit_count and Digit_valid are unchanged.
  - Digit_out holds its value between commits.
- Clear, on a CLEAR press event: the next cycle has Clear_pulse=1 and Digit_count=0. Digit_out is unchanged.
- Simultaneous ENTER and CLEAR events in the same cycle: clear wins. The commit is dropped silently, with no Reject_pulse.
- Entry_full is combinational from Digit_count.
- Digit_valid, Clear_pulse and Reject_pulse are mutually exclusive in any cycle.
- RESET asserted mid-debounce or mid-pulse aborts everything immediately. No pending event fires after reset deasserts.
- Counter width: $clog2 of the larger of DEBOUNCE_CYCLES and TIMEOUT_CYCLES; the counter saturates and never wraps.

Optional Feature:
ENTRY_TIMEOUT_EN.
- Defined: an idle counter runs while 0 < Digit_count < MAX_DIGITS. Any ENTER or CLEAR press event resets the counter. On reaching TIMEOUT_CYCLES-1, the block behaves exactly as a CLEAR event (Clear_pulse, Digit_count=0). A full entry never times out.
- Undefined: no idle counter exists and a partial entry persists indefinitely.

Decomposition:
- Shared package sale_terminal_pkg holds:
  - the debounce state encoding (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the constant BARCODE_DIGITS=4;
  - the constant MAX_BCD=9.
- Natural sub-module: button_debouncer (2-flop synchroniser, debounce FSM, press-event output, DEBOUNCE_CYCLES parameter), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20 in sim):
- SW=7, ENTER held low for 10 cycles -> exactly one Digit_valid pulse with Digit_out=7; Digit_count=1.
- ENTER glitches low for 2 cycles, 3 times -> no Digit_valid; Digit_count stays 0.
- Commit 1,2,3,4 then a 5th ENTER with SW=5 -> four Digit_valid pulses, Entry_full=1, one Reject_pulse; Digit_out stays 4.
- SW=12, ENTER pressed -> Reject_pulse=1; Digit_count unchanged at 0.
- ENTER and CLEAR press events in the same cycle with Digit_count=2 -> Clear_pulse=1, no Digit_valid, no Reject_pulse; Digit_count=0.
- With ENTRY_TIMEOUT_EN: commit one digit, then idle 20 cycles -> Clear_pulse=1 and Digit_count=0. RESET asserted during PRESS_WAIT -> no event after release.
